// File: rtl/score_pkg.sv
// Shared score widths, win threshold and types for the snake score path.
// Latency: none (declarations only).
// Backpressure: none.
package score_pkg;

    localparam int SCORE_W   = 8;
    localparam int WIN_SCORE = 100;

    typedef logic [7:0] score_t;
    typedef logic [3:0] bcd_digit_t;

    // Larger of two scores, used when folding a finished game into the high score.
    function automatic score_t max_score(input score_t a, input score_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bin_to_bcd8.sv
// Binary (8-bit) to three-digit BCD conversion via shift-and-add-3.
// Latency: purely combinational.
// Backpressure: none; output follows input continuously.
module bin_to_bcd8
    import score_pkg::*;
(
    input  score_t     bin,
    output bcd_digit_t ones,
    output bcd_digit_t tens,
    output bcd_digit_t hundreds
);

    // Working register: {hundreds, tens, ones, binary} shifted left one bit per step.
    logic [19:0] sr;

    // Double-dabble: before each shift, bump any digit >= 5 by 3 so it carries correctly.
    always_comb begin
        sr = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (sr[11:8] >= 4'd5) begin
                sr[11:8] = sr[11:8] + 4'd3;
            end
            if (sr[15:12] >= 4'd5) begin
                sr[15:12] = sr[15:12] + 4'd3;
            end
            if (sr[19:16] >= 4'd5) begin
                sr[19:16] = sr[19:16] + 4'd3;
            end
            sr = sr << 1;
        end
    end

    assign ones     = sr[11:8];
    assign tens     = sr[15:12];
    assign hundreds = sr[19:16];

endmodule

// File: rtl/score_tracker3.sv
// Snake score keeper: current score, session high score, game-over flag, BCD display digits.
// Latency: state updates on the collision edge; display outputs combinational from the registers.
// Backpressure: none; collision levels are consumed every rising clk edge.
module score_tracker3
    import score_pkg::*;
#(
    parameter int WIN_SCORE = score_pkg::WIN_SCORE,
    parameter int SCORE_W   = score_pkg::SCORE_W
)(
    input  logic               clk,
    input  logic               nRst,
    input  logic               goodColl,
    input  logic               badColl,
    output logic [SCORE_W-1:0] current_score,
    output logic [SCORE_W-1:0] dispScore,
    output logic               isGameComplete,
    output logic [3:0]         bcd_ones,
    output logic [3:0]         bcd_tens,
    output logic [3:0]         bcd_hundreds
);

    localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] ONE_VAL = SCORE_W'(1);

    logic [SCORE_W-1:0] current_q;
    logic [SCORE_W-1:0] high_q;
    logic               done_q;

    logic [SCORE_W-1:0] score_inc;
    logic               at_win;

    // Next score if an apple is taken; the counter stops at the win score, never wraps.
    always_comb begin
        score_inc = current_q;
        if (current_q != WIN_VAL) begin
            score_inc = current_q + ONE_VAL;
        end
        at_win = (score_inc == WIN_VAL);
    end

    // Game state: game-over freezes scoring until the next apple restarts play at 1.
    always_ff @(posedge clk or posedge nRst) begin
        if (nRst) begin
            current_q <= '0;
            high_q    <= '0;
            done_q    <= 1'b0;
        end else if (done_q) begin
            // Fatal collisions mean nothing once the game is over; an apple starts afresh.
            if (goodColl) begin
                current_q <= ONE_VAL;
                done_q    <= (ONE_VAL == WIN_VAL);
            end
        end else if (badColl) begin
            // A fatal collision wins over an apple in the same cycle; the score stands.
            done_q <= 1'b1;
            high_q <= max_score(score_t'(high_q), score_t'(current_q));
        end else if (goodColl) begin
            current_q <= score_inc;
            if (at_win) begin
                done_q <= 1'b1;
                high_q <= max_score(score_t'(high_q), score_t'(WIN_VAL));
            end
        end
    end

    assign current_score  = current_q;
    assign isGameComplete = done_q;
    assign dispScore      = done_q ? high_q : current_q;

    bin_to_bcd8 u_bcd (
        .bin      (score_t'(dispScore)),
        .ones     (bcd_ones),
        .tens     (bcd_tens),
        .hundreds (bcd_hundreds)
    );

endmodule

// File: tb/tb_score_tracker3.sv
// Directed bench for score_tracker3: reset, count-to-win, losses, high-score retention, priority.
// Latency: checks one clock after each collision edge, sampled 1 time unit after the edge.
// Backpressure: none.
module tb_score_tracker3;

    logic       tb_clk;
    logic       nRst;
    logic       goodColl;
    logic       badColl;
    logic [7:0] current_score;
    logic [7:0] dispScore;
    logic       isGameComplete;
    logic [3:0] bcd_ones;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_hundreds;

    int n_asserts = 0;
    int n_fail    = 0;

    score_tracker3 #(.WIN_SCORE(100), .SCORE_W(8)) dut (
        .clk            (tb_clk),
        .nRst           (nRst),
        .goodColl       (goodColl),
        .badColl        (badColl),
        .current_score  (current_score),
        .dispScore      (dispScore),
        .isGameComplete (isGameComplete),
        .bcd_ones       (bcd_ones),
        .bcd_tens       (bcd_tens),
        .bcd_hundreds   (bcd_hundreds)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Checks every output; BCD digits are derived from the expected display value.
    task automatic chk_state(input string tag, input int e_cur, input int e_disp, input int e_done);
        chk({tag, ".current"},  32'(current_score),  32'(e_cur));
        chk({tag, ".disp"},     32'(dispScore),      32'(e_disp));
        chk({tag, ".done"},     32'(isGameComplete), 32'(e_done));
        chk({tag, ".hundreds"}, 32'(bcd_hundreds),   32'(e_disp / 100));
        chk({tag, ".tens"},     32'(bcd_tens),       32'((e_disp / 10) % 10));
        chk({tag, ".ones"},     32'(bcd_ones),       32'(e_disp % 10));
    endtask

    // Advance one clock and sample just after the edge.
    task automatic step(input logic g, input logic b);
        goodColl = g;
        badColl  = b;
        @(posedge tb_clk);
        #1;
    endtask

    task automatic do_reset();
        goodColl = 1'b0;
        badColl  = 1'b0;
        nRst     = 1'b1;
        @(posedge tb_clk);
        #1;
        nRst     = 1'b0;
    endtask

    initial begin
        // Reset held, no collisions
        nRst     = 1'b1;
        goodColl = 1'b0;
        badColl  = 1'b0;
        #1;
        chk_state("rst0", 0, 0, 0);
        @(posedge tb_clk);
        #1;
        chk_state("rst_edge", 0, 0, 0);
        step(1'b1, 1'b0);
        chk_state("rst_good_held", 0, 0, 0);
        nRst = 1'b0;

        // Count to win with goodColl held
        for (int i = 1; i <= 99; i++) begin
            step(1'b1, 1'b0);
            chk_state($sformatf("count%0d", i), i, i, 0);
            if (i == 57) begin
                chk("bcd57.h", 32'(bcd_hundreds), 32'd0);
                chk("bcd57.t", 32'(bcd_tens),     32'd5);
                chk("bcd57.o", 32'(bcd_ones),     32'd7);
            end
        end
        step(1'b1, 1'b0);
        chk_state("win100", 100, 100, 1);
        chk("win.h", 32'(bcd_hundreds), 32'd1);
        step(1'b1, 1'b0);
        chk_state("restart1", 1, 1, 0);
        step(1'b1, 1'b0);
        chk_state("restart2", 2, 2, 0);
        step(1'b0, 1'b1);
        chk_state("lose_keep_win_high", 2, 100, 1);

        // Single loss
        do_reset();
        chk_state("rst_again", 0, 0, 0);
        step(1'b1, 1'b0);
        chk_state("loss_apple", 1, 1, 0);
        step(1'b0, 1'b1);
        chk_state("loss_bad", 1, 1, 1);
        step(1'b0, 1'b1);
        chk_state("bad_ignored_done", 1, 1, 1);

        // High-score override: 2 apples then loss
        step(1'b1, 1'b0);
        chk_state("hs_a1", 1, 1, 0);
        step(1'b1, 1'b0);
        chk_state("hs_a2", 2, 2, 0);
        step(1'b0, 1'b1);
        chk_state("hs_lose2", 2, 2, 1);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b0);
            chk_state($sformatf("hs4_a%0d", i), i, i, 0);
        end
        step(1'b0, 1'b1);
        chk_state("hs_lose4", 4, 4, 1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, (i % 2) == 1);
            chk_state($sformatf("hs_hold%0d", i), 4, 4, 1);
        end

        // High retained over a lower game
        step(1'b1, 1'b0);
        chk_state("ret_a1", 1, 1, 0);
        step(1'b0, 1'b1);
        chk_state("ret_lose", 1, 4, 1);

        // Both inputs while done: apple starts a new game
        step(1'b1, 1'b1);
        chk_state("sim_done_restart", 1, 1, 0);
        step(1'b1, 1'b0);
        chk_state("sim_a2", 2, 2, 0);
        step(1'b1, 1'b0);
        chk_state("sim_a3", 3, 3, 0);
        // Both inputs while playing: bad wins, score stays
        step(1'b1, 1'b1);
        chk_state("sim_play_bad", 3, 4, 1);

        // Same, but with a lower high so the max picks current
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 1'b0);
        end
        chk_state("sim2_a3", 3, 3, 0);
        step(1'b1, 1'b1);
        chk_state("sim2_bad", 3, 3, 1);

        // Reset mid-game: outputs clear without a clock edge
        step(1'b1, 1'b0);
        for (int i = 2; i <= 7; i++) begin
            step(1'b1, 1'b0);
        end
        chk_state("mid7", 7, 7, 0);
        goodColl = 1'b0;
        #1;
        nRst = 1'b1;
        #1;
        chk_state("async_rst", 0, 0, 0);
        nRst = 1'b0;
        step(1'b1, 1'b0);
        chk_state("post_rst_a1", 1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/score_tracker3.md
Name: score_tracker3

Overview:
- Tracks the snake game's current score and session high score.
- Counts apple collisions (goodColl) and ends the game on a border/self collision (badColl) or on reaching the win score.
- Drives the display value as an 8-bit binary plus 3-digit BCD for the seven-segment driver.
- Sits between the collision detector and the display/game-control logic.

Parameters:
- WIN_SCORE, 100: current score at which the game ends as a win.
- SCORE_W, 8: width of score registers and outputs.

Ports:
- clk  in  1  system clock.
- nRst  in  1  reset; asynchronous, active-high (asserted when 1), despite the name.
- goodColl  in  1  apple eaten this cycle; level, sampled each rising clk edge.
- badColl  in  1  fatal collision this cycle; level, sampled each rising clk edge.
- current_score  out  8  score of the game in progress or just ended.
- dispScore  out  8  value to display.
- isGameComplete  out  1  high while the game is over.
- bcd_ones  out  4  BCD ones digit of dispScore.
- bcd_tens  out  4  BCD tens digit of dispScore.
- bcd_hundreds  out  4  BCD hundreds digit of dispScore.

Behaviour:
- State registers: current (8b), high (8b), done (1b). All update on the rising edge of clk.
- Reset (nRst=1, async): current=0, high=0, done=0. Therefore dispScore=0, all BCD digits=0, isGameComplete=0. Reset asserted mid-game discards all scores immediately.
- Playing (done=0):
  - goodColl=1 and badColl=0: current += 1 each clock. goodColl held for N cycles scores N.
  - If the new value equals WIN_SCORE: done<=1 and high<=max(high, WIN_SCORE) in the same edge.
- Playing, badColl=1 (regardless of goodColl): done<=1, high<=max(high, current), current unchanged. badColl has priority over goodColl.
- Game over (done=1):
  - badColl is ignored.
  - goodColl=1 starts a new game: current<=1, done<=0. That apple counts.
  - high is retained.
- Outputs:
  - isGameComplete = done.
  - current_score = current.
  - dispScore = high when done=1, otherwise current.
- Latency: registered state; dispScore is valid one clock after the collision edge, and combinational from the registers.
- Width: current never exceeds WIN_SCORE (≤255). Counter saturates at WIN_SCORE and never wraps.
- BCD: pure combinational binary-to-BCD (double-dabble) of dispScore; hundreds ≤ 2.

Decomposition:
- Shared package score_pkg: SCORE_W, WIN_SCORE, typedef score_t (logic [7:0]), typedef bcd_digit_t (logic [3:0]).
- Sub-module bin_to_bcd8: converts an 8-bit binary value to ones/tens/hundreds. It is combinational and instantiated once on dispScore.

Test Plan:
- Reset: hold nRst=1, both collision inputs 0 → dispScore=0, current_score=0, isGameComplete=0, BCD digits=0, including across a clock edge.
- Count to win: after reset, hold goodColl=1 for 100 consecutive cycles → scores step 1..99 with correct BCD (e.g. 57 → 0/5/7). At 100, isGameComplete=1 and dispScore=100 (BCD 1/0/0). Further cycles with goodColl=1 restart at 1.
- Single loss: one goodColl pulse → dispScore=1; one badColl pulse → dispScore=1, isGameComplete=1.
- High-score override:
  - 2 apples, badColl → dispScore=2.
  - 4 apples → dispScore reads 1, 2, 3, 4, isGameComplete=0.
  - badColl → dispScore=4, held for 5+ cycles.
- High retained: after high=4, new game with 1 apple then badColl → dispScore=4, current_score=1.
- Simultaneous: goodColl=badColl=1 while playing with score 3 → current stays 3, game over, dispScore=max(high,3). Reset mid-game with score 7 → all outputs 0 immediately, without waiting for a clock edge.
